multicycle_datapath: RTL

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/mcdp_pkg.sv | 48 ++++
 rtl/mcdp_regfile.sv | 37 +++
 rtl/multicycle_datapath.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mcdp_pkg.sv
// Shared encodings for the multicycle datapath: opcodes, functs, ALU ops,
// FSM states and the instruction legality/ALU-op decoder.
package mcdp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    legal;
  } dec_t;

  // Non-R-type instructions that need the ALU all use it as an adder.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.alu_op = ALU_ADD;
    d.legal  = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_SLT:  d.alu_op = ALU_SLT;
          default: d.legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: d.alu_op = ALU_ADD;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mcdp_regfile.sv
// General register file: two async read ports, one sync write port.
// Register 0 is hardwired to zero; index bits above log2(REG_COUNT) are dropped.
module mcdp_regfile #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int AW = $clog2(REG_COUNT);

  logic [REG_COUNT-1:0][DATA_W-1:0] regs;
  logic [AW-1:0] ia1, ia2, iw;

  assign ia1 = ra1[AW-1:0];
  assign ia2 = ra2[AW-1:0];
  assign iw  = wa[AW-1:0];

  assign rd1 = (ia1 == '0) ? '0 : regs[ia1];
  assign rd2 = (ia2 == '0) ? '0 : regs[ia2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      regs <= '0;
    else if (we && iw != '0)
      regs[iw] <= wd;
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB FSM over a single
// req/ack memory port, halting permanently on an illegal instruction.
module multicycle_datapath
  import mcdp_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                REG_COUNT = 32,
  parameter logic [DATA_W-1:0] PC_RESET  = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] pc,
  output logic              halt
);

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  state_e            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, imm_q, alu_q, mdr_q;
  alu_op_e           alu_op_q;

  logic [5:0]        op;
  dec_t              dec;
  logic [DATA_W-1:0] rd1, rd2, alu_b, alu_y, exec_pc;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              unused_shamt;

  assign op           = ir[31:26];
  assign dec          = decode(ir[31:26], ir[5:0]);
  assign unused_shamt = ^ir[10:6];

  assign wr_en   = (state == S_WB);
  assign wr_addr = (op == OP_RTYPE) ? ir[15:11] : ir[20:16];
  assign wr_data = (op == OP_LW) ? mdr_q : alu_q;

  mcdp_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
    .clk  (clk),
    .reset(reset),
    .ra1  (ir[25:21]),
    .ra2  (ir[20:16]),
    .rd1  (rd1),
    .rd2  (rd2),
    .we   (wr_en),
    .wa   (wr_addr),
    .wd   (wr_data)
  );

  always_comb begin
    alu_b = (op == OP_RTYPE) ? b_q : imm_q;
    case (alu_op_q)
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      default: alu_y = a_q + alu_b;
    endcase
  end

  // pc already points past the branch/jump when EXEC runs.
  always_comb begin
    exec_pc = pc;
    if (op == OP_BEQ && a_q == b_q)
      exec_pc = pc + (imm_q << 2);
    else if (op == OP_J)
      exec_pc = {pc[DATA_W-1:28], ir[25:0], 2'b00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= PC_RESET;
      ir        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= PC_RESET;
      mem_wdata <= '0;
      halt      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      alu_op_q  <= ALU_ADD;
    end else begin
      case (state)
        S_FETCH: begin
          // Only the very first fetch after reset arrives here with mem_req low.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata[31:0];
            pc      <= pc + PC_STEP;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q      <= rd1;
          b_q      <= rd2;
          imm_q    <= {{(DATA_W-16){ir[15]}}, ir[15:0]};
          alu_op_q <= dec.alu_op;
          if (dec.legal) begin
            state <= S_EXEC;
          end else begin
            state <= S_HALT;
            halt  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (op == OP_LW || op == OP_SW) begin
            alu_q     <= alu_y;
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_SW);
            mem_addr  <= alu_y;
            mem_wdata <= b_q;
            state     <= S_MEM;
          end else if (op == OP_BEQ || op == OP_J) begin
            pc       <= exec_pc;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= exec_pc;
            state    <= S_FETCH;
          end else begin
            alu_q <= alu_y;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (mem_we) begin
              // Store done: the request line stays up and becomes the next fetch.
              mem_addr <= pc;
              state    <= S_FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          state    <= S_FETCH;
        end
        S_HALT: halt <= 1'b1;
        default: begin
          state   <= S_HALT;
          halt    <= 1'b1;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
